// File: rtl/ps2_keyboard_tx.sv
// PS/2 keyboard-side transmitter: byte FIFO in, 11-bit PS/2 frames out.
// Both ps2_clk and ps2_data are registered and lag the FSM state by one
// cycle, so the start bit appears two cycles after the pop decision.
module ps2_keyboard_tx #(
  parameter int HALF_PERIOD = 50,
  parameter int GAP_CYCLES  = 200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int MAXC = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC);

  localparam logic [TW-1:0] HP_LOAD  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT = 4'd10;

  typedef enum logic [1:0] {IDLE, SETUP, LOW, GAP} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [3:0]      bit_idx;
  logic [10:0]     frame;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [7:0]      head;
  logic            push;
  logic            pop;

  assign in_ready = (fifo_count < CW'(FIFO_DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state == IDLE) && (fifo_count != '0);
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE);

  // FIFO storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame FSM with registered line outputs derived from the current state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      frame    <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      ps2_clk  <= (state != LOW);
      ps2_data <= ((state == SETUP) || (state == LOW)) ? frame[bit_idx] : 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            frame   <= {1'b1, ~^head, head, 1'b0};
            bit_idx <= '0;
            timer   <= HP_LOAD;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (timer == '0) begin
            timer <= HP_LOAD;
            state <= LOW;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        LOW: begin
          if (timer == '0) begin
            if (bit_idx == LAST_BIT) begin
              timer <= GAP_LOAD;
              state <= GAP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              timer   <= HP_LOAD;
              state   <= SETUP;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GAP: begin
          if (timer == '0) state <= IDLE;
          else             timer <= timer - TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Directed bench for ps2_keyboard_tx with a small falling-edge PS/2 receiver.
// Expected frames are written as {stop, parity, D[7:0], start}.
module tb_ps2_keyboard_tx;

  localparam int HP  = 4;
  localparam int GAP = 8;
  localparam int FD  = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [2:0] fifo_count;

  int vectors = 0;
  int miscompares = 0;

  // bench-side receiver
  int          rx_bits = 0;
  int          falls = 0;
  logic [10:0] rx_sr = '0;
  logic [10:0] rx_q[$];

  ps2_keyboard_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Sample data on each ps2_clk fall; a reset discards any partial frame
  always @(negedge ps2_clk or negedge resetn) begin
    if (!resetn) begin
      rx_bits = 0;
    end else begin
      falls = falls + 1;
      rx_sr[rx_bits] = ps2_data;
      rx_bits = rx_bits + 1;
      if (rx_bits == 11) begin
        rx_q.push_back(rx_sr);
        rx_bits = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_one(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!((busy == 1'b0) && (fifo_count == 3'd0)) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic expect_frame(input string tag, input logic [10:0] exp);
    logic [10:0] f;
    if (rx_q.size() == 0) begin
      chk({tag, "_missing"}, 0, 1);
    end else begin
      f = rx_q.pop_front();
      chk(tag, {21'd0, f}, {21'd0, exp});
    end
  endtask

  initial begin
    int bad;
    int f0;
    int bc;
    int n;
    int run;
    int idx;
    int accepted;
    int maxcnt;
    int full_ready_bad;
    int base;
    logic [7:0] bytes4 [4];

    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_clk",   {31'd0, ps2_clk}, 1);
    chk("rst_data",  {31'd0, ps2_data}, 1);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_count", {29'd0, fifo_count}, 0);
    chk("rst_ready", {31'd0, in_ready}, 1);
    resetn = 1'b1;

    // Idle: nothing pushed for 1000 cycles
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_lines", bad, 0);
    chk("idle_frames", rx_q.size(), 0);

    // Single byte 0x1C: start-bit latency, busy length, 11 falls, bits
    f0 = falls;
    push_one(8'h1C);
    chk("pop_wait_data", {31'd0, ps2_data}, 1);
    chk("pop_wait_busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("setup_busy", {31'd0, busy}, 1);
    chk("setup_data_lag", {31'd0, ps2_data}, 1);
    @(negedge clk);
    chk("start_bit", {31'd0, ps2_data}, 0);
    chk("start_clk", {31'd0, ps2_clk}, 1);
    bc = 2;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      else break;
    end
    chk("busy_cycles", bc, 22 * HP + GAP);
    wait_idle(500);
    chk("falls_1c", falls - f0, 11);
    chk("end_clk", {31'd0, ps2_clk}, 1);
    chk("end_data", {31'd0, ps2_data}, 1);
    expect_frame("frame_1c", 11'h438);

    // Parity corners, pushed on consecutive cycles
    bytes4[0] = 8'h00; bytes4[1] = 8'hFF; bytes4[2] = 8'hF0; bytes4[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = bytes4[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(2000);
    expect_frame("frame_00", 11'h600);
    expect_frame("frame_ff", 11'h7FE);
    expect_frame("frame_f0", 11'h7E0);
    expect_frame("frame_01", 11'h402);
    chk("parity_extra", rx_q.size(), 0);

    // Make/break F0 1C back-to-back; both-high run = GAP + IDLE cycle
    base = rx_q.size();
    @(negedge clk); in_valid = 1'b1; in_data = 8'hF0;
    @(negedge clk); in_data = 8'h1C;
    @(negedge clk); in_valid = 1'b0;
    n = 0;
    while (rx_q.size() == base && n < 500) begin @(negedge clk); n++; end
    chk("mb_first_timeout", (n < 500) ? 1 : 0, 1);
    n = 0;
    while (ps2_clk == 1'b0 && n < 50) begin @(negedge clk); n++; end
    run = 0;
    while (ps2_clk == 1'b1 && ps2_data == 1'b1 && run < 100) begin @(negedge clk); run++; end
    chk("mb_gap_run", run, GAP + 1);
    wait_idle(1000);
    expect_frame("mb_f0", 11'h7E0);
    expect_frame("mb_1c", 11'h438);

    // FIFO full: offer 01..08 until the first frame completes
    base = rx_q.size();
    idx = 1;
    accepted = 0;
    maxcnt = 0;
    full_ready_bad = 0;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      n++;
      if (rx_q.size() != base || idx > 8) break;
      in_valid = 1'b1;
      in_data  = 8'(idx);
      if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
      if (fifo_count == 3'd4 && in_ready) full_ready_bad++;
      if (in_ready) begin
        accepted++;
        idx++;
      end
    end
    in_valid = 1'b0;
    chk("full_accepted", accepted, 5);
    chk("full_maxcount", maxcnt, 4);
    chk("full_ready_low", full_ready_bad, 0);
    wait_idle(3000);
    expect_frame("full_01", 11'h402);
    expect_frame("full_02", 11'h404);
    expect_frame("full_03", 11'h606);
    expect_frame("full_04", 11'h408);
    expect_frame("full_05", 11'h60A);
    chk("full_extra", rx_q.size(), 0);

    // Reset during bit 5 of 0xAA with two bytes queued
    base = rx_q.size();
    f0 = falls;
    @(negedge clk); in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk); in_data = 8'h11;
    @(negedge clk); in_data = 8'h22;
    @(negedge clk); in_valid = 1'b0;
    n = 0;
    while ((falls - f0) < 6 && n < 500) begin @(negedge clk); n++; end
    chk("rst_mid_timeout", (n < 500) ? 1 : 0, 1);
    chk("rst_mid_inframe", {31'd0, busy}, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_clk",   {31'd0, ps2_clk}, 1);
    chk("arst_data",  {31'd0, ps2_data}, 1);
    chk("arst_busy",  {31'd0, busy}, 0);
    chk("arst_count", {29'd0, fifo_count}, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("post_rst_lines", bad, 0);
    chk("post_rst_frames", rx_q.size() - base, 0);
    chk("post_rst_count", {29'd0, fifo_count}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
